// File: rtl/tq_qp_sched.sv
`default_nettype none
// ============================================================================
// Module      : tq_qp_sched
// Description : Per-4x4-block scheduler for the H.264 transform/quant path.
//               Accepts a block request (base QP + signed delta), forms the
//               wrapped block QP, derives QP/6, QP%6 and qbits with a
//               sequential subtract-by-6 divider, then streams COEF_CNT
//               raster coefficient indices to the quantiser over a
//               valid/ready handshake and pulses done.
// Ports       : clk_i        clock
//               rst_ni       synchronous reset, active-low
//               start_i      block request valid
//               start_rdy_o  request can be accepted (registered, IDLE only)
//               qp_base_i    base QP, values above QP_MAX treated as QP_MAX
//               qp_delta_i   signed QP delta, clamped to [-26,+25]
//               intra_i      block is intra
//               abort_i      synchronous abort back to IDLE, no done
//               coef_vld_o   coefficient index valid
//               coef_rdy_i   quantiser accepts current index
//               coef_idx_o   raster coefficient index
//               last_o       current index is COEF_CNT-1
//               qp_o         block QP
//               qp_div6_o    qp_o / 6
//               qp_mod6_o    qp_o % 6
//               qbits_o      QBITS_B + qp_div6_o
//               intra_o      latched intra_i
//               busy_o       scheduler not idle
//               done_o       one-cycle pulse after final coefficient
// Revision    : 1.0 - initial release
// ============================================================================
module tq_qp_sched #(
    parameter int COEF_CNT = 16,
    parameter int QP_MAX   = 51,
    parameter int QBITS_B  = 15,
    localparam int IDX_W   = $clog2(COEF_CNT)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    output logic             start_rdy_o,
    input  logic [5:0]       qp_base_i,
    input  logic [6:0]       qp_delta_i,
    input  logic             intra_i,
    input  logic             abort_i,
    output logic             coef_vld_o,
    input  logic             coef_rdy_i,
    output logic [IDX_W-1:0] coef_idx_o,
    output logic             last_o,
    output logic [5:0]       qp_o,
    output logic [3:0]       qp_div6_o,
    output logic [2:0]       qp_mod6_o,
    output logic [4:0]       qbits_o,
    output logic             intra_o,
    output logic             busy_o,
    output logic             done_o
);

    // State encoding
    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_calc  = 2'd1;
    localparam logic [1:0] c_st_issue = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    localparam logic [5:0]        c_qp_max   = 6'(QP_MAX);
    localparam logic signed [7:0] c_qp_max_s = 8'(QP_MAX);
    localparam logic signed [7:0] c_qp_span  = 8'(QP_MAX + 1);
    localparam logic signed [6:0] c_dlt_min  = -7'sd26;
    localparam logic signed [6:0] c_dlt_max  = 7'sd25;
    localparam logic [4:0]        c_qbits_b  = 5'(QBITS_B);
    localparam logic [IDX_W-1:0]  c_idx_last = IDX_W'(COEF_CNT - 1);
    localparam logic [5:0]        c_six      = 6'd6;

    // Registers
    logic [1:0]       r_state;
    logic             r_start_rdy;
    logic [5:0]       r_qp;
    logic [5:0]       r_rem;
    logic [3:0]       r_quo;
    logic [3:0]       r_div6;
    logic [2:0]       r_mod6;
    logic [4:0]       r_qbits;
    logic             r_intra;
    logic [IDX_W-1:0] r_idx;
    logic             r_vld;
    logic             r_done;

    // Combinational
    logic [1:0]        w_state_nxt;
    logic [5:0]        w_base_clamp;
    logic signed [6:0] w_delta_s;
    logic signed [6:0] w_delta_clamp;
    logic signed [7:0] w_sum;
    logic signed [7:0] w_wrap;
    logic [5:0]        w_qp_new;
    logic              w_accept;
    logic              w_handshake;
    logic              w_is_last;

    // ------------------------------------------------------------------
    // Block QP formation: clamp base and delta, add in 8-bit signed and
    // wrap once into 0..QP_MAX (the clamped range never needs a second
    // wrap: sum lies in [-26, QP_MAX+25]).
    // ------------------------------------------------------------------
    always_comb begin
        w_base_clamp  = (qp_base_i > c_qp_max) ? c_qp_max : qp_base_i;
        w_delta_s     = $signed(qp_delta_i);
        w_delta_clamp = w_delta_s;
        if (w_delta_s < c_dlt_min) begin
            w_delta_clamp = c_dlt_min;
        end else if (w_delta_s > c_dlt_max) begin
            w_delta_clamp = c_dlt_max;
        end
        w_sum  = $signed({2'b00, w_base_clamp}) + $signed({w_delta_clamp[6], w_delta_clamp});
        w_wrap = w_sum;
        if (w_sum < 8'sd0) begin
            w_wrap = w_sum + c_qp_span;
        end else if (w_sum > c_qp_max_s) begin
            w_wrap = w_sum - c_qp_span;
        end
        w_qp_new = 6'(w_wrap);
    end

    // A request is only taken once start_rdy_o is visibly high, so the
    // cycle straight after reset release never accepts.
    assign w_accept    = (r_state == c_st_idle) && start_i && r_start_rdy;
    assign w_handshake = r_vld && coef_rdy_i;
    assign w_is_last   = (r_idx == c_idx_last);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_accept) begin
                    w_state_nxt = c_st_calc;
                end
            end
            c_st_calc: begin
                if (r_rem < c_six) begin
                    w_state_nxt = c_st_issue;
                end
            end
            c_st_issue: begin
                if (w_handshake && w_is_last) begin
                    w_state_nxt = c_st_done;
                end
            end
            c_st_done: begin
                w_state_nxt = c_st_idle;
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
        if (abort_i) begin
            w_state_nxt = c_st_idle;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Datapath / output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_start_rdy <= 1'b0;
            r_qp        <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_div6      <= '0;
            r_mod6      <= '0;
            r_qbits     <= '0;
            r_intra     <= 1'b0;
            r_idx       <= '0;
            r_vld       <= 1'b0;
            r_done      <= 1'b0;
        end else if (abort_i) begin
            // QP-related outputs deliberately keep their last values.
            r_vld       <= 1'b0;
            r_done      <= 1'b0;
            r_start_rdy <= 1'b1;
        end else begin
            case (r_state)
                c_st_idle: begin
                    r_done <= 1'b0;
                    if (w_accept) begin
                        r_qp        <= w_qp_new;
                        r_intra     <= intra_i;
                        r_rem       <= w_qp_new;
                        r_quo       <= '0;
                        r_start_rdy <= 1'b0;
                    end else begin
                        r_start_rdy <= 1'b1;
                    end
                end
                c_st_calc: begin
                    if (r_rem >= c_six) begin
                        r_rem <= r_rem - c_six;
                        r_quo <= r_quo + 4'd1;
                    end else begin
                        r_div6  <= r_quo;
                        r_mod6  <= r_rem[2:0];
                        r_qbits <= c_qbits_b + {1'b0, r_quo};
                        r_idx   <= '0;
                        r_vld   <= 1'b1;
                    end
                end
                c_st_issue: begin
                    if (w_handshake) begin
                        if (w_is_last) begin
                            // Index stays at the last value; no wrap in-block.
                            r_vld  <= 1'b0;
                            r_done <= 1'b1;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                c_st_done: begin
                    r_done      <= 1'b0;
                    r_start_rdy <= 1'b1;
                end
                default: begin
                    r_vld  <= 1'b0;
                    r_done <= 1'b0;
                end
            endcase
        end
    end

    assign start_rdy_o = r_start_rdy;
    assign coef_vld_o  = r_vld;
    assign coef_idx_o  = r_idx;
    assign last_o      = r_vld && w_is_last;
    assign qp_o        = r_qp;
    assign qp_div6_o   = r_div6;
    assign qp_mod6_o   = r_mod6;
    assign qbits_o     = r_qbits;
    assign intra_o     = r_intra;
    assign busy_o      = (r_state != c_st_idle);
    assign done_o      = r_done;

endmodule
`default_nettype wire
